rgb2bayer_mosaic: RTL and testbench



---
 rtl/rgb2bayer_mosaic_pkg.sv | 17 +
 rtl/rgb2bayer_mosaic_frame_tracker.sv | 121 ++++++++++++
 rtl/rgb2bayer_mosaic.sv | 105 ++++++++++
 tb/tb_rgb2bayer_mosaic.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2bayer_mosaic_pkg.sv
// Shared stream type codes and helpers for the RGB-to-Bayer re-mosaic stage.
// Pixel dtypes are any code with a bit in DTYPE_PIXEL_MASK set.
package rgb2bayer_mosaic_pkg;

    localparam int DTYPE_WIDTH = 8;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 8'h01;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 8'h02;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 8'h03;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 8'h04;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 8'h80;

    function automatic logic dtype_is_pixel(input logic [DTYPE_WIDTH-1:0] dt);
        return (dt & DTYPE_PIXEL_MASK) != '0;
    endfunction

endpackage

// File: rtl/rgb2bayer_mosaic_frame_tracker.sv
// Frame/row structure tracker: IDLE/FRAME/ROW FSM, saturating row/column counters,
// sticky framing-error flag and last-completed row/frame dimensions.
module rgb2bayer_mosaic_frame_tracker
    import rgb2bayer_mosaic_pkg::*;
#(
    parameter int NUM_COLS_WIDTH = 11,
    parameter int NUM_ROWS_WIDTH = 11
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      valid_i,
    input  logic [DTYPE_WIDTH-1:0]    dtype_i,
    output logic                      framing_err_o,
    output logic [NUM_COLS_WIDTH-1:0] num_cols_o,
    output logic [NUM_ROWS_WIDTH-1:0] num_rows_o,
    output logic [1:0]                state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_ROW   = 2'd2
    } track_state_e;

    track_state_e              state_q, state_d;
    logic                      err_q, err_d;
    logic [NUM_COLS_WIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [NUM_ROWS_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [NUM_COLS_WIDTH-1:0] num_cols_q, num_cols_d;
    logic [NUM_ROWS_WIDTH-1:0] num_rows_q, num_rows_d;

    logic is_fs, is_fe, is_rs, is_re, is_pix;

    assign is_fs  = (dtype_i == DTYPE_FRAME_START);
    assign is_fe  = (dtype_i == DTYPE_FRAME_END);
    assign is_rs  = (dtype_i == DTYPE_ROW_START);
    assign is_re  = (dtype_i == DTYPE_ROW_END);
    assign is_pix = dtype_is_pixel(dtype_i);

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        num_cols_d = num_cols_q;
        num_rows_d = num_rows_q;
        if (!enable_i) begin
            state_d   = ST_IDLE;
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else if (valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_fs) begin
                        state_d   = ST_FRAME;
                        err_d     = 1'b0;
                        row_cnt_d = '0;
                    end else if (is_pix || is_rs || is_re || is_fe) begin
                        err_d = 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (is_rs) begin
                        state_d   = ST_ROW;
                        col_cnt_d = '0;
                    end else if (is_fe) begin
                        state_d    = ST_IDLE;
                        num_rows_d = row_cnt_q;
                    end else if (is_fs) begin
                        // Restart the frame but keep the error visible for it.
                        err_d     = 1'b1;
                        row_cnt_d = '0;
                    end else if (is_pix || is_re) begin
                        err_d = 1'b1;
                    end
                end
                ST_ROW: begin
                    if (is_pix) begin
                        if (!(&col_cnt_q)) col_cnt_d = col_cnt_q + NUM_COLS_WIDTH'(1);
                    end else if (is_re) begin
                        state_d    = ST_FRAME;
                        num_cols_d = col_cnt_q;
                        if (!(&row_cnt_q)) row_cnt_d = row_cnt_q + NUM_ROWS_WIDTH'(1);
                    end else if (is_fs) begin
                        state_d   = ST_FRAME;
                        err_d     = 1'b1;
                        row_cnt_d = '0;
                    end else if (is_rs || is_fe) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            num_cols_q <= '0;
            num_rows_q <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            num_cols_q <= num_cols_d;
            num_rows_q <= num_rows_d;
        end
    end

    assign framing_err_o = err_q;
    assign num_cols_o    = num_cols_q;
    assign num_rows_o    = num_rows_q;
    assign state_o       = state_q;

endmodule

// File: rtl/rgb2bayer_mosaic.sv
// Re-mosaics a framed RGB stream into a single-channel Bayer stream with one
// cycle of registered latency; framing words and meta data pass through.
module rgb2bayer_mosaic
    import rgb2bayer_mosaic_pkg::*;
#(
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_COLS    = 1288,
    parameter int MAX_ROWS    = 1024,
    localparam int NUM_COLS_WIDTH = $clog2(MAX_COLS + 1),
    localparam int NUM_ROWS_WIDTH = $clog2(MAX_ROWS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      dvi,
    input  logic [DTYPE_WIDTH-1:0]    dtypei,
    input  logic [PIXEL_WIDTH-1:0]    r,
    input  logic [PIXEL_WIDTH-1:0]    g,
    input  logic [PIXEL_WIDTH-1:0]    b,
    input  logic [DATA_WIDTH-1:0]     meta_datai,
    input  logic [1:0]                phase,
    output logic                      dvo,
    output logic [DTYPE_WIDTH-1:0]    dtypeo,
    output logic [DATA_WIDTH-1:0]     datao,
    output logic                      framing_err,
    output logic [NUM_COLS_WIDTH-1:0] num_cols,
    output logic [NUM_ROWS_WIDTH-1:0] num_rows,
    output logic [1:0]                dbg_state
);

    logic                   accept;
    logic                   is_pix;
    logic                   row_phase_q, row_phase_d;
    logic                   col_phase_q, col_phase_d;
    logic                   dvo_q, dvo_d;
    logic [DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
    logic [DATA_WIDTH-1:0]  datao_q, datao_d;
    logic [PIXEL_WIDTH-1:0] comp;

    // A word presented while disabled is dropped entirely.
    assign accept = dvi & enable;
    assign is_pix = dtype_is_pixel(dtypei);

    always_comb begin
        comp = g;
        case ({row_phase_q, col_phase_q})
            2'd0:    comp = r;
            2'd3:    comp = b;
            default: comp = g;
        endcase
    end

    always_comb begin
        row_phase_d = row_phase_q;
        col_phase_d = col_phase_q;
        dvo_d       = accept;
        dtypeo_d    = dtypeo_q;
        datao_d     = datao_q;
        if (accept) begin
            dtypeo_d = dtypei;
            datao_d  = is_pix ? DATA_WIDTH'(comp) : meta_datai;
            if (dtypei == DTYPE_FRAME_START) row_phase_d = phase[1];
            if (dtypei == DTYPE_ROW_START)   col_phase_d = phase[0];
            if (dtypei == DTYPE_ROW_END)     row_phase_d = ~row_phase_q;
            if (is_pix)                      col_phase_d = ~col_phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_phase_q <= 1'b0;
            col_phase_q <= 1'b0;
            dvo_q       <= 1'b0;
            dtypeo_q    <= '0;
            datao_q     <= '0;
        end else begin
            row_phase_q <= row_phase_d;
            col_phase_q <= col_phase_d;
            dvo_q       <= dvo_d;
            dtypeo_q    <= dtypeo_d;
            datao_q     <= datao_d;
        end
    end

    rgb2bayer_mosaic_frame_tracker #(
        .NUM_COLS_WIDTH (NUM_COLS_WIDTH),
        .NUM_ROWS_WIDTH (NUM_ROWS_WIDTH)
    ) u_frame_tracker (
        .clk_i         (clk),
        .rst_i         (reset),
        .enable_i      (enable),
        .valid_i       (dvi),
        .dtype_i       (dtypei),
        .framing_err_o (framing_err),
        .num_cols_o    (num_cols),
        .num_rows_o    (num_rows),
        .state_o       (dbg_state)
    );

    assign dvo    = dvo_q;
    assign dtypeo = dtypeo_q;
    assign datao  = datao_q;

endmodule

// File: tb/tb_rgb2bayer_mosaic.sv
// Directed bench for rgb2bayer_mosaic: phase patterns, round-trip mosaic,
// framing violations, enable drop, async reset and counter saturation.
module tb_rgb2bayer_mosaic;
  import rgb2bayer_mosaic_pkg::*;

  localparam logic [7:0] FS   = 8'h01;
  localparam logic [7:0] FE   = 8'h02;
  localparam logic [7:0] RS   = 8'h03;
  localparam logic [7:0] RE   = 8'h04;
  localparam logic [7:0] PIX  = 8'h80;
  localparam logic [7:0] META = 8'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        dvi = 1'b0;
  logic [7:0]  dtypei = '0;
  logic [9:0]  r = '0, g = '0, b = '0;
  logic [15:0] meta_datai = '0;
  logic [1:0]  phase = '0;
  logic        dvo;
  logic [7:0]  dtypeo;
  logic [15:0] datao;
  logic        framing_err;
  logic [10:0] num_cols;
  logic [10:0] num_rows;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rgb2bayer_mosaic dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .dvi         (dvi),
    .dtypei      (dtypei),
    .r           (r),
    .g           (g),
    .b           (b),
    .meta_datai  (meta_datai),
    .phase       (phase),
    .dvo         (dvo),
    .dtypeo      (dtypeo),
    .datao       (datao),
    .framing_err (framing_err),
    .num_cols    (num_cols),
    .num_rows    (num_rows),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one word for one clock; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic [7:0] dt, input logic [9:0] rr, input logic [9:0] gg,
                      input logic [9:0] bb, input logic [15:0] md);
    dvi = 1'b1;
    dtypei = dt;
    r = rr;
    g = gg;
    b = bb;
    meta_datai = md;
    @(posedge clk);
    #1;
    dvi = 1'b0;
  endtask

  task automatic ctl(input logic [7:0] dt);
    send(dt, 10'd0, 10'd0, 10'd0, 16'h0000);
  endtask

  task automatic pix_chk(input string tag, input logic [15:0] exp);
    send(PIX, 10'd100, 10'd200, 10'd300, 16'h0000);
    chk({tag, " dvo"}, dvo, 1);
    chk(tag, datao, exp);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] bayer;
    logic [9:0] rr, gg, bb;
    logic [1:0] sel;

    // Reset state
    #2;
    chk("rst dvo", dvo, 0);
    chk("rst dtypeo", dtypeo, 0);
    chk("rst datao", datao, 0);
    chk("rst err", framing_err, 0);
    chk("rst num_cols", num_cols, 0);
    chk("rst num_rows", num_rows, 0);
    chk("rst state", dbg_state, 0);
    idle();
    reset = 1'b0;
    idle();

    // Phase 0, 2x4 frame
    phase = 2'd0;
    send(FS, 10'd0, 10'd0, 10'd0, 16'h00AB);
    chk("p0 fs dvo", dvo, 1);
    chk("p0 fs dtypeo", dtypeo, FS);
    chk("p0 fs meta", datao, 16'h00AB);
    chk("p0 fs state", dbg_state, 1);
    ctl(RS);
    chk("p0 rs state", dbg_state, 2);
    pix_chk("p0 r0c0", 100);
    pix_chk("p0 r0c1", 200);
    pix_chk("p0 r0c2", 100);
    pix_chk("p0 r0c3", 200);
    ctl(RE);
    ctl(RS);
    pix_chk("p0 r1c0", 200);
    pix_chk("p0 r1c1", 300);
    pix_chk("p0 r1c2", 200);
    pix_chk("p0 r1c3", 300);
    ctl(RE);
    ctl(FE);
    chk("p0 num_cols", num_cols, 4);
    chk("p0 num_rows", num_rows, 2);
    chk("p0 err", framing_err, 0);
    chk("p0 state", dbg_state, 0);
    idle();
    chk("idle dvo", dvo, 0);
    chk("idle datao hold", datao, 0);

    // Phase 3, same frame
    phase = 2'd3;
    ctl(FS);
    ctl(RS);
    pix_chk("p3 r0c0", 300);
    pix_chk("p3 r0c1", 200);
    pix_chk("p3 r0c2", 300);
    pix_chk("p3 r0c3", 200);
    ctl(RE);
    ctl(RS);
    pix_chk("p3 r1c0", 200);
    pix_chk("p3 r1c1", 100);
    pix_chk("p3 r1c2", 200);
    pix_chk("p3 r1c3", 100);
    ctl(RE);
    ctl(FE);
    chk("p3 num_cols", num_cols, 4);
    chk("p3 num_rows", num_rows, 2);
    chk("p3 err", framing_err, 0);

    // Round trip: a random Bayer sample placed in the CFA position for its pixel
    phase = 2'($urandom_range(0, 3));
    ctl(FS);
    for (int y = 0; y < 8; y++) begin
      ctl(RS);
      for (int x = 0; x < 8; x++) begin
        bayer = 10'($urandom_range(0, 1023));
        rr = 10'($urandom_range(0, 1023));
        gg = 10'($urandom_range(0, 1023));
        bb = 10'($urandom_range(0, 1023));
        sel = {phase[1] ^ y[0], phase[0] ^ x[0]};
        if (sel == 2'd0) rr = bayer;
        else if (sel == 2'd3) bb = bayer;
        else gg = bayer;
        send(PIX, rr, gg, bb, 16'h0000);
        chk("rt sample", datao, {6'd0, bayer});
      end
      ctl(RE);
    end
    ctl(FE);
    chk("rt num_cols", num_cols, 8);
    chk("rt num_rows", num_rows, 8);
    chk("rt err", framing_err, 0);

    // Pixel before ROW_START: flagged and still forwarded
    phase = 2'd0;
    ctl(FS);
    chk("viol pre err", framing_err, 0);
    send(PIX, 10'd77, 10'd77, 10'd77, 16'h0000);
    chk("viol err", framing_err, 1);
    chk("viol fwd data", datao, 77);
    chk("viol fwd dtype", dtypeo, PIX);
    chk("viol state", dbg_state, 1);
    send(META, 10'd0, 10'd0, 10'd0, 16'h1234);
    chk("meta data", datao, 16'h1234);
    chk("meta err sticky", framing_err, 1);
    ctl(FE);
    chk("viol fe err sticky", framing_err, 1);
    ctl(FS);
    chk("fs clears err", framing_err, 0);

    // FRAME_START inside a row restarts the frame with the error set
    ctl(RS);
    send(PIX, 10'd1, 10'd2, 10'd3, 16'h0000);
    ctl(FS);
    chk("fs in row err", framing_err, 1);
    chk("fs in row state", dbg_state, 1);
    ctl(RS);
    ctl(PIX);
    ctl(PIX);
    ctl(PIX);
    ctl(RE);
    ctl(FE);
    chk("restart num_cols", num_cols, 3);
    chk("restart num_rows", num_rows, 1);
    chk("restart err", framing_err, 1);

    // Word presented while disabled is dropped
    enable = 1'b0;
    send(FS, 10'd0, 10'd0, 10'd0, 16'h5555);
    chk("dis dvo", dvo, 0);
    chk("dis dtypeo hold", dtypeo, FE);
    chk("dis state", dbg_state, 0);
    chk("dis err hold", framing_err, 1);
    chk("dis num_cols hold", num_cols, 3);
    enable = 1'b1;

    // Asynchronous reset in the middle of a row
    ctl(FS);
    ctl(RS);
    pix_chk("pre rst c0", 100);
    pix_chk("pre rst c1", 200);
    #2;
    reset = 1'b1;
    #1;
    chk("mid rst dvo", dvo, 0);
    chk("mid rst dtypeo", dtypeo, 0);
    chk("mid rst datao", datao, 0);
    chk("mid rst num_cols", num_cols, 0);
    chk("mid rst num_rows", num_rows, 0);
    chk("mid rst state", dbg_state, 0);
    idle();
    reset = 1'b0;
    phase = 2'd1;
    ctl(FS);
    ctl(RS);
    pix_chk("p1 c0", 200);
    pix_chk("p1 c1", 100);
    ctl(RE);
    ctl(FE);
    chk("p1 num_cols", num_cols, 2);
    chk("p1 num_rows", num_rows, 1);
    chk("p1 err", framing_err, 0);

    // Long rows: plain count, then saturation at all-ones
    ctl(FS);
    ctl(RS);
    for (int i = 0; i < 1300; i++) ctl(PIX);
    ctl(RE);
    chk("long num_cols", num_cols, 1300);
    ctl(RS);
    for (int i = 0; i < 2100; i++) ctl(PIX);
    ctl(RE);
    chk("sat num_cols", num_cols, 2047);
    ctl(FE);
    chk("sat num_rows", num_rows, 2);
    chk("sat err", framing_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
